// File: rtl/avalon_multi_timer.sv
// Multi-channel Avalon-MM interval timer: N_CH down-counters behind one slave port,
// sharing a global prescaler, synchronous multi-channel start and a W1C pending register.

module avalon_multi_timer_ch #(
  parameter int DATA_W    = 32,
  parameter int RESET_PER = 19999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              period_wr,
  input  logic              ctrl_wr,
  input  logic              status_wr,
  input  logic              snap_wr,
  input  logic              sync_start,
  input  logic              pend_clr,
  input  logic [DATA_W-1:0] wdata,
  output logic              run,
  output logic              to,
  output logic              ito,
  output logic              cont,
  output logic [DATA_W-1:0] period,
  output logic [DATA_W-1:0] snap
);
  localparam logic [DATA_W-1:0] PER_RST = DATA_W'(RESET_PER);
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

  logic [DATA_W-1:0] cnt;
  logic start, stop, count, evt;

  // START beats STOP; a START on a running channel must not stall the count.
  assign start = (ctrl_wr & wdata[2]) | sync_start;
  assign stop  = ctrl_wr & wdata[3] & ~start;
  assign count = run & tick & ~stop & ~period_wr;
  assign evt   = count & (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= PER_RST;
      period <= PER_RST;
      run    <= 1'b0;
    end else if (period_wr) begin
      period <= wdata;
      cnt    <= wdata;
      run    <= 1'b0;
    end else begin
      if (count) cnt <= evt ? period : cnt - ONE;
      if (start)     run <= 1'b1;
      else if (stop) run <= 1'b0;
      else if (evt)  run <= cont;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ito  <= 1'b0;
      cont <= 1'b0;
      to   <= 1'b0;
      snap <= '0;
    end else begin
      if (ctrl_wr) begin
        ito  <= wdata[0];
        cont <= wdata[1];
      end
      // a timeout coinciding with a clear must not be lost
      to <= evt | (to & ~(status_wr | pend_clr));
      if (snap_wr) snap <= cnt;
    end
  end
endmodule

module avalon_multi_timer #(
  parameter  int N_CH      = 4,
  parameter  int DATA_W    = 32,
  parameter  int RESET_PER = 19999,
  localparam int CH_W      = $clog2(N_CH + 1),
  localparam int ADDR_W    = CH_W + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [N_CH-1:0]   irq_vec,
  output logic              irq
);
  localparam logic [CH_W-1:0] GBLK = CH_W'(N_CH);

  logic              write;
  logic [CH_W-1:0]   blk;
  logic [1:0]        rsel;
  logic              gsel, pre_wr, tick;
  logic [15:0]       prescale, pcnt;
  logic [N_CH-1:0]   run, to, ito, cont, sync_start, pend_clr;
  logic [N_CH-1:0][DATA_W-1:0] period, snap;
  logic [DATA_W-1:0] rd_next;

  assign write  = chipselect & ~write_n;
  assign blk    = address[ADDR_W-1:2];
  assign rsel   = address[1:0];
  assign gsel   = write & (blk == GBLK);
  assign pre_wr = gsel & (rsel == 2'd1);

  assign sync_start = (gsel & (rsel == 2'd2)) ? writedata[N_CH-1:0] : '0;
  assign pend_clr   = (gsel & (rsel == 2'd0)) ? writedata[N_CH-1:0] : '0;

  // A PRESCALE write restarts the prescaler phase and swallows that cycle's tick.
  assign tick = (pcnt == prescale) & ~pre_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (pre_wr) prescale <= writedata[15:0];
      pcnt <= (pre_wr | tick) ? '0 : pcnt + 16'd1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic csel;
    assign csel = write & (blk == CH_W'(i));

    avalon_multi_timer_ch #(
      .DATA_W    (DATA_W),
      .RESET_PER (RESET_PER)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (tick),
      .period_wr  (csel & (rsel == 2'd2)),
      .ctrl_wr    (csel & (rsel == 2'd1)),
      .status_wr  (csel & (rsel == 2'd0)),
      .snap_wr    (csel & (rsel == 2'd3)),
      .sync_start (sync_start[i]),
      .pend_clr   (pend_clr[i]),
      .wdata      (writedata),
      .run        (run[i]),
      .to         (to[i]),
      .ito        (ito[i]),
      .cont       (cont[i]),
      .period     (period[i]),
      .snap       (snap[i])
    );
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (blk == CH_W'(i)) begin
        case (rsel)
          2'd0:    rd_next = DATA_W'({run[i], to[i]});
          2'd1:    rd_next = DATA_W'({cont[i], ito[i]});
          2'd2:    rd_next = period[i];
          default: rd_next = snap[i];
        endcase
      end
    end
    if (blk == GBLK) begin
      case (rsel)
        2'd0:    rd_next = DATA_W'(to);
        2'd1:    rd_next = DATA_W'(prescale);
        default: rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq_vec = to & ito;
  assign irq     = |irq_vec;
endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed self-checking bench for avalon_multi_timer (N_CH=4, DATA_W=32).
// Writes/reads are issued 1 time unit after a rising edge; outputs sampled there too.

module tb_avalon_multi_timer;
  localparam int N_CH = 4, DATA_W = 32, RESET_PER = 19999, ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [DATA_W-1:0] writedata = '0;
  logic [DATA_W-1:0] readdata;
  logic [N_CH-1:0]   irq_vec;
  logic              irq;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] d;

  avalon_multi_timer #(.N_CH(N_CH), .DATA_W(DATA_W), .RESET_PER(RESET_PER)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_vec    (irq_vec),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    address = a;
    @(posedge clk); #1;
    v = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL rst_readdata got %h want 0", readdata); end
    n_cmp++; if ({irq_vec, irq} !== 5'b0) begin n_bad++; $display("FAIL rst_irq got %b/%b want 0", irq_vec, irq); end
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    rd(5'd2, d);
    n_cmp++; if (d !== 32'd19999) begin n_bad++; $display("FAIL rst_period got %0d want 19999", d); end
    rd(5'd17, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_prescale got %h want 0", d); end
    rd(5'd1, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_control got %h want 0", d); end
  endtask

  task automatic test_periodic;
    wr(5'd2, 32'd9);
    wr(5'd1, 32'h7);
    idle(9);
    n_cmp++; if (irq_vec !== 4'b0000) begin n_bad++; $display("FAIL t1_early got %b want 0000", irq_vec); end
    idle(1);
    n_cmp++; if ({irq_vec, irq} !== 5'b00011) begin n_bad++; $display("FAIL t1_first got %b/%b want 0001/1", irq_vec, irq); end
    wr(5'd0, 32'd0);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL t1_clear got %b want 0", irq); end
    idle(8);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL t1_gap got %b want 0", irq); end
    idle(1);
    n_cmp++; if (irq_vec !== 4'b0001) begin n_bad++; $display("FAIL t1_second got %b want 0001", irq_vec); end
    rd(5'd0, d);
    n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL t1_status got %h want 3", d); end
    wr(5'd1, 32'h8);
    wr(5'd0, 32'd0);
  endtask

  task automatic test_oneshot;
    wr(5'd17, 32'd3);
    wr(5'd6, 32'd4);
    idle(2);
    wr(5'd5, 32'h5);
    idle(19);
    n_cmp++; if (irq_vec[1] !== 1'b0) begin n_bad++; $display("FAIL t2_early got %b want 0", irq_vec[1]); end
    idle(1);
    n_cmp++; if (irq_vec !== 4'b0010) begin n_bad++; $display("FAIL t2_timeout got %b want 0010", irq_vec); end
    rd(5'd4, d);
    n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL t2_status got %h want 1", d); end
    wr(5'd7, 32'd0);
    rd(5'd7, d);
    n_cmp++; if (d !== 32'd4) begin n_bad++; $display("FAIL t2_reload got %0d want 4", d); end
    wr(5'd4, 32'd0);
    idle(40);
    n_cmp++; if (irq_vec !== 4'b0000) begin n_bad++; $display("FAIL t2_no_retrig got %b want 0000", irq_vec); end
    rd(5'd4, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL t2_idle_status got %h want 0", d); end
  endtask

  task automatic test_sync_start;
    logic [3:0] exp_t [6] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    wr(5'd17, 32'd0);
    for (int i = 0; i < N_CH; i++) begin
      wr(5'(i * 4 + 2), 32'(i + 2));
      wr(5'(i * 4 + 1), 32'h3);
    end
    wr(5'd16, 32'hF);
    wr(5'd18, 32'hF);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      n_cmp++; if (irq_vec !== exp_t[k]) begin n_bad++; $display("FAIL t3_clk%0d got %b want %b", k + 1, irq_vec, exp_t[k]); end
    end
    rd(5'd16, d);
    n_cmp++; if (d !== 32'hF) begin n_bad++; $display("FAIL t3_pend got %h want f", d); end
    wr(5'd16, 32'h5);
    n_cmp++; if (irq_vec !== 4'b1010) begin n_bad++; $display("FAIL t3_w1c got %b want 1010", irq_vec); end
    rd(5'd16, d);
    n_cmp++; if (d !== 32'hA) begin n_bad++; $display("FAIL t3_pend_rd got %h want a", d); end
    rd(5'd18, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL t3_sync_rd got %h want 0", d); end
    for (int i = 0; i < N_CH; i++) wr(5'(i * 4 + 2), 32'd1000);
    wr(5'd16, 32'hF);
    idle(5);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL t3_quiet got %b want 0", irq); end
  endtask

  task automatic test_clear_race;
    wr(5'd2, 32'd2);
    wr(5'd1, 32'h7);
    idle(2);
    wr(5'd0, 32'd0);
    n_cmp++; if ({irq_vec[0], irq} !== 2'b11) begin n_bad++; $display("FAIL t4_race got %b%b want 11", irq_vec[0], irq); end
    rd(5'd0, d);
    n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL t4_status got %h want 3", d); end
    wr(5'd2, 32'd1000);
    wr(5'd0, 32'd0);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL t4_cleared got %b want 0", irq); end
    wr(5'd13, 32'hC);
    rd(5'd12, d);
    n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL t4_start_stop got %h want 2", d); end
    rd(5'd13, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL t4_strobe_rb got %h want 0", d); end
  endtask

  task automatic test_period_snap;
    wr(5'd10, 32'd20);
    wr(5'd9, 32'h4);
    idle(13);
    wr(5'd11, 32'hDEAD);
    rd(5'd11, d);
    n_cmp++; if (d !== 32'd7) begin n_bad++; $display("FAIL t5_snap got %0d want 7", d); end
    wr(5'd10, 32'd33);
    rd(5'd8, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL t5_run_off got %h want 0", d); end
    wr(5'd11, 32'd0);
    rd(5'd11, d);
    n_cmp++; if (d !== 32'd33) begin n_bad++; $display("FAIL t5_cnt_load got %0d want 33", d); end
    rd(5'd10, d);
    n_cmp++; if (d !== 32'd33) begin n_bad++; $display("FAIL t5_period got %0d want 33", d); end
  endtask

  task automatic test_reset_mid;
    wr(5'd2, 32'd2);
    wr(5'd1, 32'h7);
    idle(3);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL t6_pre got %b want 1", irq); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({readdata, irq_vec, irq} !== 37'd0) begin n_bad++; $display("FAIL t6_async got %h/%b/%b want 0", readdata, irq_vec, irq); end
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    rd(5'd2, d);
    n_cmp++; if (d !== 32'd19999) begin n_bad++; $display("FAIL t6_period got %0d want 19999", d); end
    idle(5);
    rd(5'd0, d);
    n_cmp++; if (d !== 32'd0 || irq !== 1'b0) begin n_bad++; $display("FAIL t6_no_to got %h/%b want 0/0", d, irq); end
    wr(5'd20, 32'h1234);
    rd(5'd20, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL t6_unmapped got %h want 0", d); end
    rd(5'd19, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL t6_reserved got %h want 0", d); end
    rd(5'd2, d);
    n_cmp++; if (d !== 32'd19999) begin n_bad++; $display("FAIL t6_no_alias got %0d want 19999", d); end
  endtask

  initial begin
    test_reset;
    test_periodic;
    test_oneshot;
    test_sync_start;
    test_clear_race;
    test_period_snap;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
